// File: rtl/cb_io_driver_app.sv
// Command-driven output driver: per-channel set/clear/toggle/timed-pulse with a
// minimum dwell after every output edge so the driven IO lines cannot chatter.
module cb_io_driver_app #(
    parameter int OUT_NUM  = 16,
    parameter int CH_W     = 4,
    parameter int CNT_W    = 16,
    parameter int HOLD_CNT = 8
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [CH_W-1:0]    cmd_ch_i,
    input  logic [1:0]         cmd_op_i,
    input  logic [CNT_W-1:0]   cmd_len_i,
    output logic [OUT_NUM-1:0] out_o,
    output logic [OUT_NUM-1:0] busy_o,
    output logic               cmd_err_o
);

    localparam int               PAD_N     = 2 ** CH_W;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CNT);
    localparam logic [CH_W:0]    OUT_LIMIT = (CH_W + 1)'(OUT_NUM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state     [OUT_NUM];
    state_t             w_stateNext [OUT_NUM];
    logic [CNT_W-1:0]   r_cnt       [OUT_NUM];
    logic [CNT_W-1:0]   w_cntNext   [OUT_NUM];
    logic [OUT_NUM-1:0] r_out;
    logic [OUT_NUM-1:0] w_outNext;
    logic               r_err;
    logic               w_inRange;
    logic               w_accept;
    logic               w_newLvl;
    logic [PAD_N-1:0]   w_busyPad;
    logic [CNT_W-1:0]   w_pulseLen;

    always_comb begin
        for (int i = 0; i < OUT_NUM; i++) begin
            busy_o[i] = (r_state[i] != ST_IDLE);
        end
    end

    // Busy vector padded to the full channel address space so any index is legal.
    always_comb begin
        w_busyPad                = '0;
        w_busyPad[OUT_NUM-1:0]   = busy_o;
    end

    assign w_inRange   = ({1'b0, cmd_ch_i} < OUT_LIMIT);
    assign cmd_ready_o = w_inRange ? ~w_busyPad[cmd_ch_i] : 1'b1;
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    assign w_pulseLen  = (cmd_len_i == '0) ? CNT_W'(1) : cmd_len_i;

    always_comb begin
        w_outNext = r_out;
        w_newLvl  = 1'b0;
        for (int i = 0; i < OUT_NUM; i++) begin
            w_stateNext[i] = r_state[i];
            w_cntNext[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    // Commands only land on idle channels; a coinciding tick is ignored.
                    if (w_accept && w_inRange && (cmd_ch_i == CH_W'(i))) begin
                        if (cmd_op_i == 2'b10) begin
                            w_outNext[i]   = 1'b1;
                            w_cntNext[i]   = w_pulseLen;
                            w_stateNext[i] = ST_PULSE;
                        end else begin
                            case (cmd_op_i)
                                2'b00:   w_newLvl = 1'b0;
                                2'b01:   w_newLvl = 1'b1;
                                default: w_newLvl = ~r_out[i];
                            endcase
                            if (w_newLvl != r_out[i]) begin
                                w_outNext[i] = w_newLvl;
                                if (HOLD_CNT != 0) begin
                                    w_cntNext[i]   = HOLD_LOAD;
                                    w_stateNext[i] = ST_HOLD;
                                end
                            end
                        end
                    end
                end
                ST_PULSE: begin
                    if (tick_i) begin
                        if (r_cnt[i] == CNT_W'(1)) begin
                            w_outNext[i] = 1'b0;
                            if (HOLD_CNT != 0) begin
                                w_cntNext[i]   = HOLD_LOAD;
                                w_stateNext[i] = ST_HOLD;
                            end else begin
                                w_cntNext[i]   = '0;
                                w_stateNext[i] = ST_IDLE;
                            end
                        end else begin
                            w_cntNext[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_i) begin
                        if (r_cnt[i] == CNT_W'(1)) begin
                            w_cntNext[i]   = '0;
                            w_stateNext[i] = ST_IDLE;
                        end else begin
                            w_cntNext[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_cntNext[i]   = '0;
                    w_stateNext[i] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_NUM; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < OUT_NUM; i++) begin
                r_state[i] <= w_stateNext[i];
                r_cnt[i]   <= w_cntNext[i];
            end
            r_out <= w_outNext;
            r_err <= w_accept & ~w_inRange;
        end
    end

    assign out_o     = r_out;
    assign cmd_err_o = r_err;

endmodule

// File: tb/tb_cb_io_driver_app.sv
// Scoreboard bench for cb_io_driver_app: a tick-counting channel model predicts
// levels, busy flags and error strobes; a monitor compares them each cycle.
module tb_cb_io_driver_app;

    localparam int OUT_N = 12;
    localparam int CHW   = 4;
    localparam int CNTW  = 16;
    localparam int HOLD  = 8;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick_i = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [CHW-1:0]    cmd_ch_i = '0;
    logic [1:0]        cmd_op_i = '0;
    logic [CNTW-1:0]   cmd_len_i = '0;
    logic [OUT_N-1:0]  out_o;
    logic [OUT_N-1:0]  busy_o;
    logic              cmd_err_o;

    cb_io_driver_app #(
        .OUT_NUM (OUT_N),
        .CH_W    (CHW),
        .CNT_W   (CNTW),
        .HOLD_CNT(HOLD)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .tick_i     (tick_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_ch_i   (cmd_ch_i),
        .cmd_op_i   (cmd_op_i),
        .cmd_len_i  (cmd_len_i),
        .out_o      (out_o),
        .busy_o     (busy_o),
        .cmd_err_o  (cmd_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [OUT_N-1:0] out;
        logic [OUT_N-1:0] busy;
        logic             err;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic lastAccept = 1'b0;

    // Model: level, ticks until a pending pulse falls, ticks until the channel frees.
    logic mLvl      [OUT_N];
    int   mFall     [OUT_N];
    int   mBusyLeft [OUT_N];

    task automatic modelReset();
        for (int i = 0; i < OUT_N; i++) begin
            mLvl[i]      = 1'b0;
            mFall[i]     = 0;
            mBusyLeft[i] = 0;
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("out_o", 64'(out_o), 64'(e.out));
        checkValue("busy_o", 64'(busy_o), 64'(e.busy));
        checkValue("cmd_err_o", 64'(cmd_err_o), 64'(e.err));
    endtask

    task automatic applyStimulus(input logic v, input int ch, input int op, input int len, input logic tk);
        logic rdy;
        logic acc;
        logic newLvl;
        exp_t e;
        @(negedge sys_clk);
        cmd_valid_i = v;
        cmd_ch_i    = CHW'(ch);
        cmd_op_i    = 2'(op);
        cmd_len_i   = CNTW'(len);
        tick_i      = tk;
        #1;
        rdy = (ch >= OUT_N) ? 1'b1 : (mBusyLeft[ch] == 0);
        checkValue("cmd_ready_o", 64'(cmd_ready_o), 64'(rdy));
        acc = v && rdy;
        if (tk) begin
            for (int i = 0; i < OUT_N; i++) begin
                if (mFall[i] > 0) begin
                    mFall[i]--;
                    if (mFall[i] == 0) mLvl[i] = 1'b0;
                end
                if (mBusyLeft[i] > 0) mBusyLeft[i]--;
            end
        end
        if (acc && ch < OUT_N) begin
            if (op == 2) begin
                mLvl[ch]      = 1'b1;
                mFall[ch]     = (len == 0) ? 1 : len;
                mBusyLeft[ch] = mFall[ch] + HOLD;
            end else begin
                newLvl = (op == 0) ? 1'b0 : (op == 1) ? 1'b1 : ~mLvl[ch];
                if (newLvl != mLvl[ch]) begin
                    mLvl[ch]      = newLvl;
                    mBusyLeft[ch] = HOLD;
                end
            end
        end
        for (int i = 0; i < OUT_N; i++) begin
            e.out[i]  = mLvl[i];
            e.busy[i] = (mBusyLeft[i] > 0);
        end
        e.err = acc && (ch >= OUT_N);
        expQ.push_back(e);
        lastAccept = acc;
        cyc++;
    endtask

    task automatic stepCmd(input logic v, input int ch, input int op, input int len);
        applyStimulus(v, ch, op, len, (cyc % 10) == 9);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) stepCmd(1'b0, 0, 0, 0);
    endtask

    always @(posedge sys_clk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        logic rv;
        int   rch;
        int   rop;
        int   rlen;

        modelReset();
        #12;
        checkValue("reset_out", 64'(out_o), 64'h0);
        checkValue("reset_busy", 64'(busy_o), 64'h0);
        checkValue("reset_err", 64'(cmd_err_o), 64'h0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        // Set ch3, then a clear that stalls through the dwell.
        stepCmd(1'b1, 3, 1, 0);
        for (int k = 0; k < 150; k++) begin
            stepCmd(1'b1, 3, 0, 0);
            if (lastAccept) break;
        end
        idle(100);

        // Pulse len 5, then len 0 behaving as len 1.
        stepCmd(1'b1, 0, 2, 5);
        idle(160);
        stepCmd(1'b1, 2, 2, 0);
        idle(120);

        // Set ch5, redundant set, immediate toggle.
        stepCmd(1'b1, 5, 1, 0);
        idle(100);
        stepCmd(1'b1, 5, 1, 0);
        stepCmd(1'b1, 5, 3, 0);
        idle(100);

        // Out-of-range channel.
        stepCmd(1'b1, 15, 1, 0);
        stepCmd(1'b1, 12, 2, 3);
        idle(5);

        rv = 1'b0;
        rch = 0;
        rop = 0;
        rlen = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(rv && !lastAccept)) begin
                rv   = ($urandom_range(0, 1) == 1);
                rch  = $urandom_range(0, 15);
                rop  = $urandom_range(0, 3);
                rlen = $urandom_range(0, 6);
            end
            applyStimulus(rv, rch, rop, rlen, $urandom_range(0, 3) == 0);
        end
        idle(200);

        // Asynchronous reset in the middle of a pulse on ch1.
        stepCmd(1'b1, 1, 2, 10);
        idle(15);
        @(posedge sys_clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkValue("async_rst_out", 64'(out_o), 64'h0);
        checkValue("async_rst_busy", 64'(busy_o), 64'h0);
        checkValue("async_rst_err", 64'(cmd_err_o), 64'h0);
        modelReset();
        cmd_valid_i = 1'b0;
        tick_i = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        stepCmd(1'b1, 1, 1, 0);
        idle(100);
        stepCmd(1'b1, 1, 0, 0);
        idle(3);

        repeat (2) @(posedge sys_clk);
        #2;
        checkValue("queue_drained", 64'(expQ.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cb_io_driver_app.md
# cb_io_driver_app

Output-side counterpart of the photoelectric input filter array. It drives OUT_NUM actuator/indicator IO lines from a single command port written by the NIOS II register bridge. Each channel supports set, clear, toggle and timed-pulse commands, and enforces a minimum dwell time after every output edge so the driven IO cannot chatter. It sits between the CPU-side command decoder and the FPGA output pins, in the sys_clk domain.

## Interface
Parameters:
- OUT_NUM, 16, number of output channels (1..64)
- CH_W, 4, channel index width; must satisfy 2^CH_W >= OUT_NUM
- CNT_W, 16, pulse-length counter width
- HOLD_CNT, 8, minimum dwell after any output edge, in ticks; 0 disables dwell

Ports:
- sys_clk  in  1  system clock; the only clock
- rst_n  in  1  reset; asynchronous and active-low
- tick_i  in  1  time-base strobe, one sys_clk cycle wide
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_ch_i  in  CH_W  target channel
- cmd_op_i  in  2  operation: 00 clear, 01 set, 10 pulse, 11 toggle
- cmd_len_i  in  CNT_W  pulse length in ticks; used only by op 10
- out_o  out  OUT_NUM  registered output levels
- busy_o  out  OUT_NUM  per-channel busy: PULSE or HOLD state
- cmd_err_o  out  1  one-cycle strobe when a command targets a channel index >= OUT_NUM

## Operation
- Each channel runs an independent FSM (IDLE, PULSE, HOLD) with a CNT_W-bit down-counter. The counter must also hold HOLD_CNT.
- Handshake:
  - cmd_ready_o = ~busy_o[cmd_ch_i] when cmd_ch_i < OUT_NUM, else 1. It is combinational from cmd_ch_i.
  - A command is accepted on a sys_clk edge with cmd_valid_i & cmd_ready_o.
  - Holding cmd_valid_i high while ready is low stalls without loss. Command fields must stay stable while stalled.
- Out-of-range channel: the command is accepted and discarded, cmd_err_o pulses in the next cycle, and no channel changes.
- IDLE, on accept:
  - set / clear / toggle: compute the new level.
    - If it differs from out_o[ch]: update out_o, load counter = HOLD_CNT, go to HOLD. If HOLD_CNT = 0, stay in IDLE instead.
    - If it does not differ: no change, stay in IDLE.
  - pulse: out_o[ch] <= 1, counter <= max(cmd_len_i, 1), go to PULSE. This applies even if the output is already high.
- PULSE: on each tick_i, decrement. A tick while counter == 1 drives out_o[ch] <= 0 and loads HOLD_CNT, going to HOLD (or to IDLE if HOLD_CNT = 0).
- HOLD: on each tick_i, decrement. A tick while counter == 1 moves to IDLE. Output is unchanged in HOLD.
- busy_o[ch] = 1 exactly in PULSE or HOLD.

## Timing
- Reset: out_o = 0, busy_o = 0, cmd_err_o = 0, all FSMs IDLE, counters 0. Reset mid-pulse drops the output to 0 immediately, asynchronously.
- Output latency: out_o and busy_o change on the edge that accepts the command, so they are visible in the cycle after cmd_valid_i & cmd_ready_o.
- A tick_i coinciding with the accept cycle is not counted.
- Pulse width: high from the accept edge until the edge of the len-th counted tick. Width is between (len-1) and len tick periods plus one sys_clk.
- Dwell: after a PULSE/explicit edge, the channel is busy until the HOLD_CNT-th counted tick. cmd_ready_o rises combinationally in the cycle after that edge.
- Simultaneous events: a tick and an accepted command on different channels are fully independent.
- Counter wrap cannot occur: decrement happens only while counter >= 1.

## Test plan
- Reset, then set ch3 (HOLD_CNT = 8, tick every 10 clk) -> out_o[3] = 1 one clk after accept. busy_o[3] = 1 for 8 ticks. A clear to ch3 issued during hold stalls, with cmd_ready_o = 0, until busy drops; out_o[3] = 0 one clk after it is accepted.
- Pulse ch0 with len = 5 -> out_o[0] high until the 5th tick edge, then low. busy_o[0] is held 8 more ticks. The total busy span is 13 ticks.
- Pulse with len = 0 -> behaves as len = 1: high until the first tick, then HOLD.
- Set ch5 while already high -> no edge, busy_o[5] stays 0, and the next command is accepted immediately. Toggle ch5 -> low, then HOLD.
- Command to ch15 with OUT_NUM = 12 -> accepted, cmd_err_o pulses one cycle, and out_o is unchanged.
- Assert rst_n low mid-pulse on ch1 -> out_o[1] = 0 and busy_o = 0 asynchronously. After release, ch1 accepts commands with no residual count.
